norm1_udiv_50ns_6ns_44_seq: RTL and testbench

Sequential unsigned restoring divider for the norm1 (LRN) datapath. It is the inverse of the 44x6 -> 50-bit unsigned product path: it takes a 50-bit dividend and a 6-bit divisor and returns a 44-bit quotient and a 6-bit remainder. It handles normalisation-scale division where a full combinational divider is too costly. Handshakes are valid/ready on both sides; one division is in flight at a time.

---
 rtl/norm1_udiv_50ns_6ns_44_seq.sv | 152 +++++++++++++++
 tb/tb_norm1_udiv_50ns_6ns_44_seq.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/norm1_udiv_50ns_6ns_44_seq.sv
// Sequential unsigned restoring divider for the norm1 (LRN) datapath.
// One quotient bit per cycle, MSB first; valid/ready handshake on both sides.
module norm1_udiv_50ns_6ns_44_seq #(
  parameter int unsigned DIVIDEND_WIDTH = 50,
  parameter int unsigned DIVISOR_WIDTH  = 6,
  parameter int unsigned QUOTIENT_WIDTH = 44
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIVIDEND_WIDTH-1:0] din0,
  input  logic [DIVISOR_WIDTH-1:0]  din1,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [QUOTIENT_WIDTH-1:0] quot,
  output logic [DIVISOR_WIDTH-1:0]  rem,
  output logic                      ovf,
  output logic                      div_by_zero
);

  localparam int unsigned CNT_W  = $clog2(DIVIDEND_WIDTH);
  localparam int unsigned PREM_W = DIVISOR_WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIVIDEND_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic                      in_ready_q, in_ready_d;
  logic                      out_valid_q, out_valid_d;
  // Dividend bits shift out of the top while quotient bits shift in at the bottom.
  logic [DIVIDEND_WIDTH-1:0] work_q, work_d;
  logic [DIVISOR_WIDTH-1:0]  divisor_q, divisor_d;
  logic [DIVISOR_WIDTH-1:0]  prem_q, prem_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [QUOTIENT_WIDTH-1:0] quot_q, quot_d;
  logic [DIVISOR_WIDTH-1:0]  rem_q, rem_d;
  logic                      ovf_q, ovf_d;
  logic                      dbz_q, dbz_d;

  logic [PREM_W-1:0]         trial_c;
  logic [PREM_W-1:0]         divisor_ext_c;
  logic                      fits_c;
  logic [DIVISOR_WIDTH-1:0]  prem_next_c;
  logic [DIVIDEND_WIDTH-1:0] work_next_c;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    trial_c       = {prem_q, work_q[DIVIDEND_WIDTH-1]};
    divisor_ext_c = {1'b0, divisor_q};
    fits_c        = (trial_c >= divisor_ext_c);
    prem_next_c   = fits_c ? DIVISOR_WIDTH'(trial_c - divisor_ext_c)
                           : DIVISOR_WIDTH'(trial_c);
    work_next_c   = {work_q[DIVIDEND_WIDTH-2:0], fits_c};
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      work_q      <= '0;
      divisor_q   <= '0;
      prem_q      <= '0;
      cnt_q       <= '0;
      quot_q      <= '0;
      rem_q       <= '0;
      ovf_q       <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      work_q      <= work_d;
      divisor_q   <= divisor_d;
      prem_q      <= prem_d;
      cnt_q       <= cnt_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      ovf_q       <= ovf_d;
      dbz_q       <= dbz_d;
    end
  end

  // Next-state and datapath control; handshake flags mirror the next state.
  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    prem_d    = prem_q;
    cnt_d     = cnt_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    ovf_d     = ovf_q;
    dbz_d     = dbz_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          work_d    = din0;
          divisor_d = din1;
          prem_d    = '0;
          cnt_d     = '0;
          if (din1 == '0) begin
            state_d = ST_DONE;
            quot_d  = '1;
            rem_d   = din0[DIVISOR_WIDTH-1:0];
            ovf_d   = 1'b0;
            dbz_d   = 1'b1;
          end else begin
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        work_d = work_next_c;
        prem_d = prem_next_c;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = ST_DONE;
          quot_d  = work_next_c[QUOTIENT_WIDTH-1:0];
          rem_d   = prem_next_c;
          ovf_d   = |work_next_c[DIVIDEND_WIDTH-1:QUOTIENT_WIDTH];
          dbz_d   = 1'b0;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quot        = quot_q;
  assign rem         = rem_q;
  assign ovf         = ovf_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_norm1_udiv_50ns_6ns_44_seq.sv
// Directed + random bench for the sequential divider, scoreboard of expected results.
module tb_norm1_udiv_50ns_6ns_44_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [49:0] din0;
  logic [5:0]  din1;
  logic        out_valid;
  logic        out_ready;
  logic [43:0] quot;
  logic [5:0]  rem;
  logic        ovf;
  logic        div_by_zero;

  norm1_udiv_50ns_6ns_44_seq dut (
    .ap_clk      (clk),
    .ap_rst_n    (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .din0        (din0),
    .din1        (din1),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quot        (quot),
    .rem         (rem),
    .ovf         (ovf),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // lat: edges after the accept edge before out_valid is seen high.
  typedef struct {
    logic [43:0] q;
    logic [5:0]  r;
    logic        ovf;
    logic        dbz;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic exp_t model(input logic [49:0] a, input logic [5:0] b);
    exp_t        e;
    logic [49:0] qf;
    if (b == 6'd0) begin
      e.q   = '1;
      e.r   = a[5:0];
      e.ovf = 1'b0;
      e.dbz = 1'b1;
      e.lat = 0;
    end else begin
      qf    = a / 50'(b);
      e.q   = qf[43:0];
      e.r   = 6'(a % 50'(b));
      e.ovf = |qf[49:44];
      e.dbz = 1'b0;
      e.lat = 50;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [49:0] a, input logic [5:0] b);
    int t = 0;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk("in_ready_before_send", 64'(in_ready), 64'd1);
    din0     = a;
    din1     = b;
    in_valid = 1'b1;
    sb.push_back(model(a, b));
    @(posedge clk); #1;
    in_valid = 1'b0;
    din0     = 50'({$urandom(), $urandom()});
    din1     = 6'($urandom_range(0, 63));
    chk("in_ready_after_accept", 64'(in_ready), 64'd0);
  endtask

  // Wait for the result, compare, optionally stall `hold` cycles, then hand off.
  task automatic collect(input string tag, input int hold);
    int   lat = 0;
    exp_t e;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 64'(sb.size()), 64'd1);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_latency"}, 64'(lat), 64'(e.lat));
    chk({tag, "_quot"}, 64'(quot), 64'(e.q));
    chk({tag, "_rem"}, 64'(rem), 64'(e.r));
    chk({tag, "_ovf"}, 64'(ovf), 64'(e.ovf));
    chk({tag, "_dbz"}, 64'(div_by_zero), 64'(e.dbz));
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      in_valid  = i[0];
      din0      = 50'({$urandom(), $urandom()});
      din1      = 6'(i % 2);
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
      chk({tag, "_hold_result"}, {11'd0, quot, rem, ovf, div_by_zero, 1'b0},
          {11'd0, e.q, e.r, e.ovf, e.dbz, 1'b0});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_handoff_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_handoff_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [49:0] a;
    logic [43:0] a44;
    logic [5:0]  b;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    din0      = '0;
    din1      = '0;
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", {12'd0, quot, rem, ovf, div_by_zero}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    out_ready = 1'b1;
    send(50'd1108307720798145, 6'd63);
    collect("max_quot", 0);
    send(50'd1000, 6'd7);
    collect("d1000_7", 0);
    send(50'h2A5, 6'd0);
    collect("div_zero", 0);
    send(50'd1 << 49, 6'd1);
    collect("ovf_top", 0);

    // Backpressure, then back-to-back accept right after the handoff.
    send(50'd123456789, 6'd11);
    collect("backpressure", 10);
    send(50'd77, 6'd5);
    collect("after_bp", 0);

    // Abort mid-computation with an asynchronous reset.
    send(50'h3_FFFF_FFFF_FFFF, 6'd13);
    repeat (20) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_result", {12'd0, quot, rem, ovf, div_by_zero}, 64'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_post_valid", 64'(out_valid), 64'd0);
    send(50'd100, 6'd10);
    collect("post_abort", 0);

    // Inverse property: (a*b)/b == a.
    for (int i = 0; i < 20; i++) begin
      a44 = 44'({$urandom(), $urandom()});
      b   = 6'($urandom_range(1, 63));
      send(50'(a44) * 50'(b), b);
      chk("inverse_model_q", 64'(sb[sb.size()-1].q), 64'(a44));
      collect("inverse", 0);
    end

    // Random operands over mixed magnitudes, including zero divisors.
    for (int i = 0; i < 150; i++) begin
      a = 50'({$urandom(), $urandom()}) >> $urandom_range(0, 49);
      b = 6'($urandom_range(0, 63));
      send(a, b);
      collect("random", (i % 25 == 0) ? 3 : 0);
    end

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
